// File: rtl/wb_req_master_if.sv
// Request/response and Wishbone signal bundle for wb_req_master.
// The master modport is the initiator's view; slave is the view of whatever drives it
// (request producer, response consumer and the Wishbone target together).
interface wb_req_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  // Request port
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_sel;

  // Response port
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  // Wishbone master port
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_wdata_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_rdata_i;
  logic          wb_ack_i;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_sel,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_wdata_o, wb_sel_o,
    input  wb_rdata_i, wb_ack_i
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_sel,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_wdata_o, wb_sel_o,
    output wb_rdata_i, wb_ack_i
  );
endinterface

// File: rtl/wb_req_master.sv
// Wishbone classic-cycle initiator: queues requests in a small FIFO, runs them one at a
// time on the Wishbone port with an ack timeout, and returns one response per request.
module wb_req_master #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  wb_req_master_if.master  bus,
  output logic             busy_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = 10;
  localparam int unsigned EW = 1 + AW + DW + SW;

  localparam logic [PW-1:0] PtrOne      = PW'(1);
  localparam logic [PW:0]   CountOne    = (PW + 1)'(1);
  localparam logic [PW:0]   CountFull   = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntOne      = CW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // Request FIFO state
  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  // Holds req_ready low through reset and for the first edge after it
  logic          r_ready_en;

  // Transfer FSM state and registered bus/response fields
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_cyc;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_sel;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;
  logic [EW-1:0] w_entry;

  assign w_full  = (r_count == CountFull);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.req_valid && bus.req_ready;
  // Pop only from IDLE, so a new entry is never taken while a response is pending
  assign w_pop   = (r_state == StIdle) && !w_empty;
  assign w_head  = r_mem[r_rptr];
  assign w_entry = {bus.req_we, bus.req_addr, bus.req_wdata, bus.req_sel};

  // FIFO storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) begin
        r_wptr <= r_wptr + PtrOne;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CountOne;
        2'b01:   r_count <= r_count - CountOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Transfer FSM: IDLE pops a request, BUS waits for ack or timeout, RESP waits for rsp_ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            {r_we, r_addr, r_wdata, r_sel} <= w_head;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= StBus;
          end
        end
        StBus: begin
          // Ack wins over a timeout landing in the same cycle
          if (bus.wb_ack_i) begin
            r_rdata <= r_we ? '0 : bus.wb_rdata_i;
            r_err   <= 1'b0;
            r_cyc   <= 1'b0;
            r_state <= StResp;
          end else if (r_cnt == TimeoutLast) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_state <= StResp;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_ready_en && !w_full;
  assign bus.rsp_valid  = (r_state == StResp);
  assign bus.rsp_rdata  = r_rdata;
  assign bus.rsp_err    = r_err;
  assign bus.wb_cyc_o   = r_cyc;
  assign bus.wb_stb_o   = r_cyc;
  assign bus.wb_we_o    = r_we;
  assign bus.wb_addr_o  = r_addr;
  assign bus.wb_wdata_o = r_wdata;
  assign bus.wb_sel_o   = r_sel;
  assign busy_o         = !w_empty || (r_state != StIdle);

endmodule
